mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_ctrl
// Purpose  : Sequencing FSM for a shift-and-add multiplier datapath
//            (two's-complement or unsigned).
// Revision : 1.0
// ============================================================================
module mult_seq_ctrl #(
  parameter int WIDTH          = 8,
  parameter bit SIGNED_DEFAULT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_run,
  input  logic                         i_clear_a_load_b,
  input  logic                         i_m,
  input  logic                         i_signed_sel,
  output logic                         o_add,
  output logic                         o_sub,
  output logic                         o_shift_en,
  output logic                         o_clear_xa,
  output logic                         o_load_b,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(WIDTH+1)-1:0]   o_iter
);

  localparam int                    c_ITER_W = $clog2(WIDTH + 1);
  localparam logic [c_ITER_W-1:0]   c_LAST   = c_ITER_W'(WIDTH - 1);
  localparam logic [c_ITER_W-1:0]   c_FULL   = c_ITER_W'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_HALT  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_rst_sync;
  logic [c_ITER_W-1:0]   r_iter;
  logic                  r_mode;
  logic                  r_need_release;
  logic                  w_ready;
  logic                  w_start;

  // Release of rst_n is retimed so the FSM cannot leave IDLE on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_ready = r_rst_sync[1];
  assign w_start = (r_state == S_IDLE) && i_run && !r_need_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (!w_ready) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The press that leaves WAIT must be released before IDLE may start again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter         <= '0;
      r_mode         <= SIGNED_DEFAULT;
      r_need_release <= 1'b0;
    end else if (w_ready) begin
      if (w_start) begin
        r_iter <= '0;
        r_mode <= i_signed_sel;
      end else if ((r_state == S_SHIFT) && (r_iter != c_FULL)) begin
        r_iter <= r_iter + c_ITER_W'(1);
      end

      if ((r_state == S_WAIT) && i_run) begin
        r_need_release <= 1'b1;
      end else if (!i_run) begin
        r_need_release <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    o_add      = 1'b0;
    o_sub      = 1'b0;
    o_shift_en = 1'b0;
    o_clear_xa = 1'b0;
    o_load_b   = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          if (!r_need_release) begin
            w_next = S_START;
          end
        end else if (i_clear_a_load_b) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        o_load_b   = 1'b1;
        o_clear_xa = 1'b1;
        w_next     = S_IDLE;
      end
      S_START: begin
        o_clear_xa = 1'b1;
        o_busy     = 1'b1;
        w_next     = S_ADD;
      end
      S_ADD: begin
        o_busy = 1'b1;
        // Sign bit of a two's-complement multiplier carries negative weight.
        if ((r_iter == c_LAST) && r_mode) begin
          o_sub = i_m;
        end else begin
          o_add = i_m;
        end
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        o_busy     = 1'b1;
        o_shift_en = 1'b1;
        w_next     = (r_iter == c_LAST) ? S_HALT : S_ADD;
      end
      S_HALT: begin
        o_done = 1'b1;
        if (!i_run) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_run) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign o_iter = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_ctrl
// Purpose  : Scoreboard bench for mult_seq_ctrl at WIDTH=8 and WIDTH=16.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mult_seq_ctrl;

  typedef logic [11:0] vec_t;  // {add,sub,shift,clr,load,busy,done,iter[4:0]}

  logic clk;
  logic rst_n;
  logic run8, clr8, m8, sgn8;
  logic run16, clr16, m16, sgn16;
  logic add8, sub8, sh8, cxa8, ld8, busy8, done8;
  logic add16, sub16, sh16, cxa16, ld16, busy16, done16;
  logic [3:0] iter8;
  logic [4:0] iter16;
  vec_t v8, v16, e8, e16;
  logic pd8, pd16, mon8_en;
  vec_t q8[$];
  vec_t q16[$];
  int checks, failures;

  mult_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_run(run8), .i_clear_a_load_b(clr8),
    .i_m(m8), .i_signed_sel(sgn8), .o_add(add8), .o_sub(sub8),
    .o_shift_en(sh8), .o_clear_xa(cxa8), .o_load_b(ld8), .o_busy(busy8),
    .o_done(done8), .o_iter(iter8)
  );

  mult_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_run(run16), .i_clear_a_load_b(clr16),
    .i_m(m16), .i_signed_sel(sgn16), .o_add(add16), .o_sub(sub16),
    .o_shift_en(sh16), .o_clear_xa(cxa16), .o_load_b(ld16), .o_busy(busy16),
    .o_done(done16), .o_iter(iter16)
  );

  // Multiplier bits 1,0,1,0,... from the LSB, as seen by the datapath each iteration.
  assign m16 = ~iter16[0];
  assign v8  = {add8, sub8, sh8, cxa8, ld8, busy8, done8, 1'b0, iter8};
  assign v16 = {add16, sub16, sh16, cxa16, ld16, busy16, done16, iter16};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(bit a, bit s, bit sh, bit c, bit l, bit b, bit d, int it);
    return {a, s, sh, c, l, b, d, 5'(it)};
  endfunction

  task automatic push(input int which, input vec_t v);
    if (which == 8) q8.push_back(v);
    else            q16.push_back(v);
  endtask

  // Expected event trace of one complete multiply: START, W ADD/SHIFT pairs, HALT entry.
  task automatic push_run(input int which, input int w, input bit sgn, input logic [31:0] mbits);
    bit mk_bit, last;
    push(which, mk(0, 0, 0, 1, 0, 1, 0, 0));
    for (int k = 0; k < w; k++) begin
      mk_bit = mbits[k];
      last   = (k == w - 1);
      push(which, mk(mk_bit && !(last && sgn), mk_bit && last && sgn, 0, 0, 0, 1, 0, k));
      push(which, mk(0, 0, 1, 0, 0, 1, 0, k));
    end
    push(which, mk(0, 0, 0, 0, 0, 0, 1, w));
  endtask

  always @(negedge clk) begin
    if (mon8_en && (busy8 || ld8 || (done8 && !pd8))) begin
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL trace8 unexpected event got=%h", v8);
      end else begin
        e8 = q8.pop_front();
        if (e8 !== v8) begin
          failures++;
          $display("FAIL trace8 got=%h exp=%h", v8, e8);
        end
      end
    end
    pd8 <= done8;
  end

  always @(negedge clk) begin
    if (busy16 || ld16 || (done16 && !pd16)) begin
      checks++;
      if (q16.size() == 0) begin
        failures++;
        $display("FAIL trace16 unexpected event got=%h", v16);
      end else begin
        e16 = q16.pop_front();
        if (e16 !== v16) begin
          failures++;
          $display("FAIL trace16 got=%h exp=%h", v16, e16);
        end
      end
    end
    pd16 <= done16;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Counts edges from the START cycle until Done is seen; optionally jiggles Run/ClearA_LoadB.
  task automatic wait_done(input int which, input bit toggle, output int n);
    n = 0;
    while (n < 200) begin
      if ((which == 8) ? done8 : done16) break;
      if (toggle) begin
        clr8 = n[0];
        run8 = n[1];
      end
      tick();
      n++;
    end
    if (toggle) begin
      clr8 = 1'b0;
      run8 = 1'b0;
    end
  endtask

  task automatic finish_run8();
    run8 = 1'b0; tick();
    run8 = 1'b1; tick();
    run8 = 1'b0; tick();
  endtask

  int  n;
  bit  bad;

  initial begin
    checks = 0; failures = 0; mon8_en = 1'b1; pd8 = 1'b0; pd16 = 1'b0;
    rst_n = 1'b0;
    run8 = 1'b1; clr8 = 1'b0; m8 = 1'b0; sgn8 = 1'b1;
    run16 = 1'b0; clr16 = 1'b0; sgn16 = 1'b1;
    repeat (3) tick();
    check("reset_out8", 32'(v8), 32'h0);
    check("reset_out16", 32'(v16), 32'h0);
    rst_n = 1'b1;
    tick();
    check("no_start_first_edge", 32'(busy8), 32'h0);
    run8 = 1'b0;
    repeat (3) tick();
    check("idle_after_reset", 32'(v8), 32'h0);

    // ClearA_LoadB alone: one LOAD cycle.
    push(8, mk(0, 0, 0, 1, 1, 0, 0, 0));
    clr8 = 1'b1; tick();
    clr8 = 1'b0; tick(); tick();

    // Signed, M=1, Run held through HALT and 100 more cycles.
    push_run(8, 8, 1'b1, 32'hFFFF_FFFF);
    m8 = 1'b1; sgn8 = 1'b1; run8 = 1'b1;
    tick();
    wait_done(8, 1'b0, n);
    check("latency_signed_m1", 32'(n), 32'd17);
    bad = 1'b0;
    repeat (100) begin
      tick();
      if (!done8 || busy8) bad = 1'b1;
    end
    check("halt_hold_run_high", 32'(bad), 32'h0);
    run8 = 1'b0; tick();
    check("wait_after_release", 32'({done8, busy8}), 32'h0);
    run8 = 1'b1; tick();
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (busy8) bad = 1'b1;
    end
    check("no_restart_held_run", 32'(bad), 32'h0);
    run8 = 1'b0; tick();

    // Unsigned, M=1: last step adds.
    push_run(8, 8, 1'b0, 32'hFFFF_FFFF);
    sgn8 = 1'b0; run8 = 1'b1;
    tick();
    check("restart_after_press", 32'(busy8), 32'h1);
    run8 = 1'b0;
    wait_done(8, 1'b0, n);
    check("latency_unsigned", 32'(n), 32'd17);
    finish_run8();

    // Signed, M=0, with Run/ClearA_LoadB toggling mid-multiply.
    push_run(8, 8, 1'b1, 32'h0);
    m8 = 1'b0; sgn8 = 1'b1; run8 = 1'b1;
    tick();
    run8 = 1'b0;
    wait_done(8, 1'b1, n);
    check("latency_m0", 32'(n), 32'd17);
    finish_run8();

    // Run and ClearA_LoadB together in IDLE: START wins, no LOAD.
    push_run(8, 8, 1'b1, 32'hFFFF_FFFF);
    m8 = 1'b1; run8 = 1'b1; clr8 = 1'b1;
    tick();
    run8 = 1'b0; clr8 = 1'b0;
    wait_done(8, 1'b0, n);
    check("latency_run_and_load", 32'(n), 32'd17);
    finish_run8();

    // WIDTH=16, alternating M.
    push_run(16, 16, 1'b1, 32'h5555_5555);
    run16 = 1'b1;
    tick();
    run16 = 1'b0;
    wait_done(16, 1'b0, n);
    check("latency_w16", 32'(n), 32'd33);
    tick(); tick();

    // Reset mid-multiply at Iter=3.
    mon8_en = 1'b0;
    m8 = 1'b1; run8 = 1'b1;
    tick();
    run8 = 1'b0;
    n = 0;
    while ((iter8 != 4'd3) && (n < 50)) begin
      tick();
      n++;
    end
    check("reach_iter3", 32'(n < 50), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(v8), 32'h0);
    tick(); tick();
    check("reset_held_out", 32'(v8), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_after_abort", 32'(v8), 32'h0);
    mon8_en = 1'b1;
    tick();

    push_run(8, 8, 1'b1, 32'hFFFF_FFFF);
    run8 = 1'b1;
    tick();
    run8 = 1'b0;
    wait_done(8, 1'b0, n);
    check("latency_after_abort", 32'(n), 32'd17);
    finish_run8();
    tick(); tick();

    check("queue8_drained", 32'(q8.size()), 32'h0);
    check("queue16_drained", 32'(q16.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
